// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/control unit for the 32-bit combinational ALU.
// Latches one MIPS instruction, loads ALU operands, then issues a write-back or branch decision.
module alu_issue_ctrl (
  input  logic        clock,
  input  logic        resetn,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  aluc,
  input  logic [31:0] alu_s,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        br_taken,
  output logic [31:0] br_offset,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

  localparam logic [3:0] AlucAdd = 4'b0000;
  localparam logic [3:0] AlucSub = 4'b0100;
  localparam logic [3:0] AlucAnd = 4'b0001;
  localparam logic [3:0] AlucOr  = 4'b0101;
  localparam logic [3:0] AlucXor = 4'b0010;
  localparam logic [3:0] AlucLui = 4'b0110;
  localparam logic [3:0] AlucSll = 4'b0011;
  localparam logic [3:0] AlucSrl = 4'b0111;
  localparam logic [3:0] AlucSra = 4'b1111;

  state_e      state_q, state_d;
  logic [31:0] inst_q;

  logic [5:0]  op, funct;
  logic [4:0]  rd, sa;
  logic [15:0] imm;

  logic        dec_ok, dec_beq, dec_bne;
  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_aluc;
  logic [4:0]  dec_dest;
  logic        zero;

  assign op      = inst_q[31:26];
  assign rs_addr = inst_q[25:21];
  assign rt_addr = inst_q[20:16];
  assign rd      = inst_q[15:11];
  assign sa      = inst_q[10:6];
  assign funct   = inst_q[5:0];
  assign imm     = inst_q[15:0];

  assign inst_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign zero       = (alu_s == 32'd0);

  // Decode the latched word into operands, ALU op, destination and branch kind.
  always_comb begin
    dec_ok   = 1'b0;
    dec_beq  = 1'b0;
    dec_bne  = 1'b0;
    dec_a    = rs_data;
    dec_b    = rt_data;
    dec_aluc = AlucAdd;
    dec_dest = rt_addr;
    case (op)
      6'b000000: begin
        dec_dest = rd;
        dec_ok   = 1'b1;
        case (funct)
          6'b100000: dec_aluc = AlucAdd;
          6'b100010: dec_aluc = AlucSub;
          6'b100100: dec_aluc = AlucAnd;
          6'b100101: dec_aluc = AlucOr;
          6'b100110: dec_aluc = AlucXor;
          6'b000000: begin dec_aluc = AlucSll; dec_a = {27'b0, sa}; end
          6'b000010: begin dec_aluc = AlucSrl; dec_a = {27'b0, sa}; end
          6'b000011: begin dec_aluc = AlucSra; dec_a = {27'b0, sa}; end
          default:   dec_ok = 1'b0;
        endcase
      end
      6'b001000: begin dec_ok = 1'b1; dec_aluc = AlucAdd; dec_b = {{16{imm[15]}}, imm}; end
      6'b001100: begin dec_ok = 1'b1; dec_aluc = AlucAnd; dec_b = {16'b0, imm}; end
      6'b001101: begin dec_ok = 1'b1; dec_aluc = AlucOr;  dec_b = {16'b0, imm}; end
      6'b001110: begin dec_ok = 1'b1; dec_aluc = AlucXor; dec_b = {16'b0, imm}; end
      6'b001111: begin dec_ok = 1'b1; dec_aluc = AlucLui; dec_b = {16'b0, imm}; end
      6'b000100: begin dec_ok = 1'b1; dec_beq = 1'b1; dec_aluc = AlucSub; end
      6'b000101: begin dec_ok = 1'b1; dec_bne = 1'b1; dec_aluc = AlucSub; end
      default:   dec_ok = 1'b0;
    endcase
  end

  // Next-state logic: illegal words bail out of DECODE straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (inst_valid) state_d = StDecode;
      StDecode: state_d = dec_ok ? StExec : StIdle;
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register and instruction latch.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      inst_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (inst_valid && inst_ready) inst_q <= inst;
    end
  end

  // Registered datapath outputs; strobes default low so each lasts exactly one cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      aluc      <= 4'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 32'd0;
      br_taken  <= 1'b0;
      br_offset <= 32'd0;
      illegal   <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      br_taken <= 1'b0;
      illegal  <= 1'b0;
      case (state_q)
        StDecode: begin
          if (dec_ok) begin
            alu_a <= dec_a;
            alu_b <= dec_b;
            aluc  <= dec_aluc;
          end else begin
            illegal <= 1'b1;
          end
        end
        StExec: begin
          wr_data <= alu_s;
          if (dec_beq || dec_bne) begin
            br_offset <= {{14{imm[15]}}, imm, 2'b00};
            br_taken  <= dec_beq ? zero : !zero;
          end else begin
            wr_addr <= dec_dest;
            // Writes to $0 are dropped here rather than in the register file.
            wr_en   <= (dec_dest != 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus randomized instructions
// compared against a mnemonic-level reference model with an attached ALU and register file.
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  aluc;
  logic [31:0] alu_s;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        illegal;
  logic        busy;

  logic [31:0] regs [32];
  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        legal;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic        wr;
    logic [4:0]  dest;
    logic        isbr;
    logic        taken;
    logic [31:0] off;
    logic [31:0] res;
  } pred_t;

  always #5 clock = ~clock;

  alu_issue_ctrl dut (
    .clock(clock), .resetn(resetn), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc), .alu_s(alu_s), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .br_taken(br_taken), .br_offset(br_offset),
    .illegal(illegal), .busy(busy)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return a & b;
      4'b0101: return a | b;
      4'b0010: return a ^ b;
      4'b0110: return {b[15:0], 16'h0000};
      4'b0011: return b << a[4:0];
      4'b0111: return b >> a[4:0];
      4'b1111: return $signed(b) >>> a[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];
  assign alu_s   = alu_ref(alu_a, alu_b, aluc);

  function automatic logic [31:0] r_type(input logic [5:0] f, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sa);
    return {6'b000000, rs, rt, rd, sa, f};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference: what the instruction means, then what the ALU and controller must show.
  function automatic pred_t predict(input logic [31:0] w);
    pred_t p;
    logic [31:0] rsv, rtv, simm, zimm;
    int signed s;
    p    = '0;
    rsv  = regs[w[25:21]];
    rtv  = regs[w[20:16]];
    s    = $signed(w[15:0]);
    simm = s;
    zimm = {16'h0000, w[15:0]};
    p.a  = rsv;
    p.b  = rtv;
    p.dest = w[20:16];
    p.legal = 1'b1;
    p.wr = 1'b1;
    if (w[31:26] == 6'b000000) begin
      p.dest = w[15:11];
      case (w[5:0])
        6'b100000: p.c = 4'b0000;
        6'b100010: p.c = 4'b0100;
        6'b100100: p.c = 4'b0001;
        6'b100101: p.c = 4'b0101;
        6'b100110: p.c = 4'b0010;
        6'b000000: begin p.c = 4'b0011; p.a = {27'd0, w[10:6]}; end
        6'b000010: begin p.c = 4'b0111; p.a = {27'd0, w[10:6]}; end
        6'b000011: begin p.c = 4'b1111; p.a = {27'd0, w[10:6]}; end
        default:   p.legal = 1'b0;
      endcase
    end else begin
      case (w[31:26])
        6'b001000: begin p.c = 4'b0000; p.b = simm; end
        6'b001100: begin p.c = 4'b0001; p.b = zimm; end
        6'b001101: begin p.c = 4'b0101; p.b = zimm; end
        6'b001110: begin p.c = 4'b0010; p.b = zimm; end
        6'b001111: begin p.c = 4'b0110; p.b = zimm; end
        6'b000100: begin p.c = 4'b0100; p.isbr = 1'b1; p.taken = (rsv == rtv); end
        6'b000101: begin p.c = 4'b0100; p.isbr = 1'b1; p.taken = (rsv != rtv); end
        default:   p.legal = 1'b0;
      endcase
    end
    p.res = alu_ref(p.a, p.b, p.c);
    p.off = s * 4;
    p.wr  = p.legal && !p.isbr && (p.dest != 5'd0);
    if (!p.legal) p.taken = 1'b0;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one word and check every phase; all steps land 1 time unit after a rising edge.
  task automatic run_inst(input logic [31:0] w, input string nm);
    pred_t p;
    int k;
    p = predict(w);
    k = 0;
    while (!inst_ready && k < 10) begin
      @(posedge clock); #1;
      k++;
    end
    check({nm, ".ready"}, 32'(inst_ready), 32'd1);
    inst = w;
    inst_valid = 1'b1;
    @(posedge clock); #1;
    inst_valid = 1'b0;
    inst = $urandom;
    check({nm, ".busy"}, 32'(busy), 32'd1);
    @(posedge clock); #1;
    if (!p.legal) begin
      check({nm, ".illegal"}, 32'(illegal), 32'd1);
      check({nm, ".idle"}, 32'(inst_ready), 32'd1);
      check({nm, ".nowr"}, 32'({wr_en, br_taken}), 32'd0);
      @(posedge clock); #1;
      check({nm, ".illegal_end"}, 32'(illegal), 32'd0);
      return;
    end
    check({nm, ".alu_a"}, alu_a, p.a);
    check({nm, ".alu_b"}, alu_b, p.b);
    check({nm, ".aluc"}, 32'(aluc), 32'(p.c));
    @(posedge clock); #1;
    check({nm, ".wr_en"}, 32'(wr_en), 32'(p.wr));
    check({nm, ".br_taken"}, 32'(br_taken), 32'(p.taken));
    check({nm, ".illegal0"}, 32'(illegal), 32'd0);
    check({nm, ".wr_data"}, wr_data, p.res);
    if (p.wr) check({nm, ".wr_addr"}, 32'(wr_addr), 32'(p.dest));
    if (p.isbr) check({nm, ".br_offset"}, br_offset, p.off);
    @(posedge clock); #1;
    check({nm, ".ready_back"}, 32'(inst_ready), 32'd1);
    check({nm, ".pulse_end"}, 32'({wr_en, br_taken, illegal}), 32'd0);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, ".alu_a"}, alu_a, 32'd0);
    check({nm, ".alu_b"}, alu_b, 32'd0);
    check({nm, ".aluc"}, 32'(aluc), 32'd0);
    check({nm, ".wr_addr"}, 32'(wr_addr), 32'd0);
    check({nm, ".wr_data"}, wr_data, 32'd0);
    check({nm, ".br_offset"}, br_offset, 32'd0);
    check({nm, ".pulses"}, 32'({wr_en, br_taken, illegal, busy}), 32'd0);
    check({nm, ".ready"}, 32'(inst_ready), 32'd1);
  endtask

  logic [5:0] functs [8];
  logic [5:0] iops [7];

  initial begin
    pred_t p;
    int seen;
    logic [31:0] w;
    logic [4:0] rs, rt;
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
               6'b000000, 6'b000010, 6'b000011};
    iops = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b000100, 6'b000101};
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    resetn = 1'b0;
    inst_valid = 1'b0;
    inst = 32'd0;
    #12;
    check_reset_state("reset");
    @(posedge clock); #1;
    resetn = 1'b1;

    // Reset in the middle of EXEC aborts the add.
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    inst = r_type(6'b100000, 5'd1, 5'd2, 5'd3, 5'd0);
    inst_valid = 1'b1;
    @(posedge clock); #1;
    inst_valid = 1'b0;
    @(posedge clock); #1;
    check("abort.in_exec_alu_a", alu_a, 32'd5);
    resetn = 1'b0;
    #1;
    check_reset_state("abort");
    @(posedge clock); #1;
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (wr_en || br_taken) seen++;
    end
    check("abort.no_wr", 32'(seen), 32'd0);

    // Directed cases.
    run_inst(r_type(6'b100000, 5'd1, 5'd2, 5'd3, 5'd0), "add");
    check("add.wr_data_12", wr_data, 32'd12);
    regs[5] = 32'h8000_0000;
    run_inst(r_type(6'b000011, 5'd0, 5'd5, 5'd4, 5'd4), "sra");
    check("sra.wr_data", wr_data, 32'hF800_0000);
    run_inst(i_type(6'b001000, 5'd1, 5'd0, 16'hFFFF), "addi_r0");
    check("addi_r0.alu_b", alu_b, 32'hFFFF_FFFF);
    regs[2] = regs[1];
    run_inst(i_type(6'b000100, 5'd1, 5'd2, 16'hFFFE), "beq_eq");
    check("beq_eq.off", br_offset, 32'hFFFF_FFF8);
    run_inst(i_type(6'b000101, 5'd1, 5'd2, 16'hFFFE), "bne_eq");
    run_inst({6'b111111, 26'd0}, "illegal_op");
    run_inst(i_type(6'b001111, 5'd0, 5'd6, 16'h1234), "lui");
    check("lui.wr_data", wr_data, 32'h1234_0000);

    // Randomized instructions against the reference model.
    for (int n = 0; n < 60; n++) begin
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      rs = 5'($urandom);
      rt = 5'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: w = r_type(functs[$urandom_range(0, 7)], rs, rt, 5'($urandom),
                               5'($urandom));
        4, 5, 6: w = i_type(iops[$urandom_range(0, 4)], rs, rt, 16'($urandom));
        7, 8: begin
          if ($urandom_range(0, 1) == 1) rt = rs;
          w = i_type(iops[$urandom_range(5, 6)], rs, rt, 16'($urandom));
        end
        default: w = ($urandom_range(0, 1) == 1) ? {6'b111111, 26'($urandom)}
                                                 : r_type(6'b111111, rs, rt, 5'd1, 5'd0);
      endcase
      p = predict(w);
      run_inst(w, p.legal ? "rand" : "rand_illegal");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
